// File: rtl/dm_access_arbiter_if.sv
// rtl/dm_access_arbiter_if.sv - CPU, debug and data-memory signal bundle for dm_access_arbiter
interface dm_access_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_wren;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_wren;
  logic          dbg_gnt;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_rvalid;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_wren,
    input  dbg_req, dbg_addr, dbg_wdata, dbg_wren,
    input  mem_q,
    output cpu_rdata, cpu_stall,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_addr, mem_wdata, mem_wren
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_wren,
    output dbg_req, dbg_addr, dbg_wdata, dbg_wren,
    output mem_q,
    input  cpu_rdata, cpu_stall,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/dm_access_arbiter.sv
// rtl/dm_access_arbiter.sv - shares single-port data memory between CPU and debug port
module dm_access_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  dm_access_arbiter_if.slave bus
);

  localparam int            WW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    DBG_ACC = 2'd1,
    DBG_RSP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;

  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_wdata_c;
  logic          mem_wren_c;
  logic          gnt_c;
  logic          stall_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CPU_OWN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Debug address is latched at grant so the response cycle does not depend on the master holding it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= (state == DBG_RSP);
      if (state == DBG_ACC) begin
        addr_q <= bus.dbg_addr;
      end
      if (state == DBG_RSP) begin
        rdata_q <= bus.mem_q;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    mem_addr_c  = bus.cpu_addr;
    mem_wdata_c = bus.cpu_wdata;
    mem_wren_c  = bus.cpu_req & bus.cpu_wren;
    gnt_c       = 1'b0;
    stall_c     = 1'b0;
    case (state)
      CPU_OWN: begin
        // CPU keeps its access this cycle; the debug access follows in the next one.
        if (bus.dbg_req && (!bus.cpu_req || wait_cnt == WAIT_LIM)) begin
          state_nxt = DBG_ACC;
        end else if (bus.dbg_req && bus.cpu_req && wait_cnt != WAIT_LIM) begin
          wait_nxt = wait_cnt + WW'(1);
        end
      end
      DBG_ACC: begin
        mem_addr_c  = bus.dbg_addr;
        mem_wdata_c = bus.dbg_wdata;
        mem_wren_c  = bus.dbg_wren;
        gnt_c       = 1'b1;
        stall_c     = 1'b1;
        wait_nxt    = '0;
        state_nxt   = bus.dbg_wren ? CPU_OWN : DBG_RSP;
      end
      DBG_RSP: begin
        mem_addr_c = addr_q;
        mem_wren_c = 1'b0;
        stall_c    = 1'b1;
        state_nxt  = CPU_OWN;
      end
      default: begin
        state_nxt = CPU_OWN;
      end
    endcase
  end

  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.mem_wren   = mem_wren_c & reset_n;
  assign bus.cpu_rdata  = bus.mem_q;
  assign bus.cpu_stall  = stall_c;
  assign bus.dbg_gnt    = gnt_c;
  assign bus.dbg_rdata  = rdata_q;
  assign bus.dbg_rvalid = rvalid_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb/tb_dm_access_arbiter.sv - randomized scoreboard bench for dm_access_arbiter
module tb_dm_access_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int MW = 4;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   cpu_mode = 0;
  logic cpu_done = 1'b0;
  txn_t          gq[$];
  logic [DW-1:0] rq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_access_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  dm_access_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();

  dm_access_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(rst_n), .bus(bus.slave)
  );
  dm_access_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(0)) dut0 (
    .clk(clk), .reset_n(rst_n), .bus(bus0.slave)
  );

  // data_memory stand-in: registered read, one cycle after the address
  logic [DW-1:0] ram [16] = '{default: '0};
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    ram_q <= ram[bus.mem_addr];
  end
  assign bus.mem_q  = ram_q;
  assign bus0.mem_q = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat);
    txn_t t;
    int   start;
    bit   ok;
    t = '{w: w, a: a, d: d};
    start = cyc;
    bus.dbg_req   = 1'b1;
    bus.dbg_wren  = w;
    bus.dbg_addr  = a;
    bus.dbg_wdata = d;
    gq.push_back(t);
    ok  = 0;
    lat = -1;
    for (int n = 0; n < 50 && !ok; n++) begin
      step();
      if (bus.dbg_gnt) begin
        ok  = 1;
        lat = cyc - start;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dbg_gnt_timeout: no grant within 50 cycles for addr %0d", a);
    end
    step();
    bus.dbg_req = 1'b0;
  endtask

  // CPU model: a new operation only after the previous one was accepted (not stalled)
  task automatic cpu_driver();
    forever begin
      step();
      if (cpu_done) begin
        case (cpu_mode)
          1: begin
            bus.cpu_req   = ($urandom_range(0, 9) < 6);
            bus.cpu_wren  = 1'($urandom_range(0, 1));
            bus.cpu_addr  = AW'($urandom_range(0, 15));
            bus.cpu_wdata = DW'($urandom);
          end
          2: begin
            bus.cpu_req  = 1'b1;
            bus.cpu_wren = 1'b0;
            bus.cpu_addr = AW'($urandom_range(0, 15));
          end
          3: begin
            bus.cpu_req   = 1'b1;
            bus.cpu_wren  = 1'b1;
            bus.cpu_addr  = AW'(5);
            bus.cpu_wdata = 8'h3C;
          end
          default: begin
            bus.cpu_req  = 1'b0;
            bus.cpu_wren = 1'b0;
          end
        endcase
      end
    end
  endtask

  // Reference: cycle schedule of debug ownership plus a plain array of memory contents.
  task automatic monitor();
    logic [DW-1:0] mdl [16];
    txn_t          t;
    int            gnt_at, rsp_at, rv_at, blocked, k;
    logic          eg, es, ev, exp_wren, cpu_pend;
    logic [DW-1:0] cpu_exp;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    gnt_at = -1; rsp_at = -1; rv_at = -1; blocked = 0;
    cpu_pend = 1'b0; cpu_exp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_dbg_gnt", bus.dbg_gnt, 1'b0);
        chk("rst_cpu_stall", bus.cpu_stall, 1'b0);
        chk("rst_dbg_rvalid", bus.dbg_rvalid, 1'b0);
        chk("rst_dbg_rdata", bus.dbg_rdata, '0);
        chk("rst_mem_wren", bus.mem_wren, 1'b0);
        gnt_at = -1; rsp_at = -1; rv_at = -1; blocked = 0;
        gq.delete();
        rq.delete();
        cpu_pend = 1'b0;
        cpu_done = 1'b0;
      end else begin
        k  = cyc;
        eg = (k == gnt_at);
        es = eg || (k == rsp_at);
        ev = (k == rv_at);
        chk("dbg_gnt_timing", bus.dbg_gnt, eg);
        chk("cpu_stall", bus.cpu_stall, es);
        chk("dbg_rvalid_timing", bus.dbg_rvalid, ev);
        if (eg) exp_wren = (gq.size() > 0) ? gq[0].w : 1'b0;
        else if (es) exp_wren = 1'b0;
        else exp_wren = bus.cpu_req & bus.cpu_wren;
        chk("mem_wren", bus.mem_wren, exp_wren);
        if (cpu_pend) chk("cpu_rdata", bus.cpu_rdata, cpu_exp);
        cpu_pend = 1'b0;
        if (!bus.cpu_stall && bus.cpu_req) begin
          if (bus.cpu_wren) mdl[bus.cpu_addr] = bus.cpu_wdata;
          else begin
            cpu_pend = 1'b1;
            cpu_exp  = mdl[bus.cpu_addr];
          end
        end
        cpu_done = !bus.cpu_stall;
        if (bus.dbg_gnt) begin
          if (gq.size() == 0) begin
            checks++; errors++;
            $display("FAIL dbg_gnt_unexpected: grant with no request outstanding at cycle %0d", cyc);
          end else begin
            t = gq.pop_front();
            chk("gnt_mem_addr", bus.mem_addr, t.a);
            if (t.w) begin
              chk("gnt_mem_wdata", bus.mem_wdata, t.d);
              mdl[t.a] = t.d;
            end else begin
              rq.push_back(mdl[t.a]);
            end
          end
        end
        if (bus.dbg_rvalid) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL dbg_rvalid_unexpected: rvalid with no read outstanding at cycle %0d", cyc);
          end else begin
            chk("dbg_rdata", bus.dbg_rdata, rq.pop_front());
          end
        end
        // A pending debug request is served once the CPU is idle or has blocked it MW times.
        if (!es && bus.dbg_req) begin
          if (!bus.cpu_req || blocked >= MW) begin
            gnt_at = k + 1;
            if (!bus.dbg_wren) begin
              rsp_at = k + 2;
              rv_at  = k + 3;
            end
            blocked = 0;
          end else if (blocked < MW) begin
            blocked++;
          end
        end
      end
    end
  endtask

  initial begin
    int lat;
    int g_prev;
    int g_now;
    bus.cpu_req = 1'b0; bus.cpu_wren = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_wren = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus0.cpu_req = 1'b0; bus0.cpu_wren = 1'b0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
    bus0.dbg_req = 1'b0; bus0.dbg_wren = 1'b0; bus0.dbg_addr = '0; bus0.dbg_wdata = '0;
    fork
      monitor();
      cpu_driver();
    join_none
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // uncontended write then read of address 3
    dbg_txn(1'b1, 4'd3, 8'hA5, lat);
    chk("uncont_wr_lat", lat, 1);
    dbg_txn(1'b0, 4'd3, 8'h00, lat);
    chk("uncont_rd_lat", lat, 1);
    step();
    chk("uncont_rd_rvalid_t3", bus.dbg_rvalid, 1'b1);
    chk("uncont_rd_data", bus.dbg_rdata, 8'hA5);

    // CPU holding the memory: debug forced through after MAX_WAIT blocked cycles
    cpu_mode = 2;
    repeat (2) step();
    dbg_txn(1'b0, 4'd9, 8'h00, lat);
    chk("blocked_rd_lat", lat, MW + 1);
    step();
    dbg_txn(1'b1, 4'd9, 8'h77, lat);
    chk("blocked_wr_lat", lat, MW + 1);
    cpu_mode = 0;
    repeat (3) step();

    // MAX_WAIT = 0 instance: debug wins immediately even against cpu_req
    bus0.cpu_req = 1'b1; bus0.dbg_req = 1'b1; bus0.dbg_wren = 1'b0; bus0.dbg_addr = 4'd2;
    chk("mw0_t0_gnt", bus0.dbg_gnt, 1'b0);
    step();
    chk("mw0_t1_gnt", bus0.dbg_gnt, 1'b1);
    chk("mw0_t1_stall", bus0.cpu_stall, 1'b1);
    bus0.dbg_req = 1'b0;
    step();
    chk("mw0_t2_gnt", bus0.dbg_gnt, 1'b0);
    chk("mw0_t2_stall", bus0.cpu_stall, 1'b1);
    step();
    chk("mw0_t3_stall", bus0.cpu_stall, 1'b0);
    chk("mw0_t3_rvalid", bus0.dbg_rvalid, 1'b1);
    bus0.cpu_req = 1'b0;

    // back-to-back reads with dbg_req held
    g_prev = -1;
    for (int i = 0; i < 4; i++) begin
      dbg_txn(1'b0, AW'(i), 8'h00, lat);
      g_now = cyc - 1;
      if (g_prev >= 0) chk("b2b_gnt_spacing", g_now - g_prev, 3);
      g_prev = g_now;
    end
    repeat (3) step();

    // CPU write to 5 lands before the debug read that arrives behind it
    cpu_mode = 3;
    repeat (2) step();
    dbg_txn(1'b0, 4'd5, 8'h00, lat);
    step();
    chk("cpu_first_rvalid", bus.dbg_rvalid, 1'b1);
    chk("cpu_first_rdata", bus.dbg_rdata, 8'h3C);
    cpu_mode = 0;
    repeat (3) step();

    // reset during the response cycle abandons the read
    dbg_txn(1'b0, 4'd7, 8'h00, lat);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_rsp_stall", bus.cpu_stall, 1'b0);
    chk("rst_mid_rsp_gnt", bus.dbg_gnt, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_rvalid_after", bus.dbg_rvalid, 1'b0);
    end

    // randomized mix against random CPU traffic
    cpu_mode = 1;
    repeat (120) begin
      repeat ($urandom_range(0, 3)) step();
      dbg_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), lat);
    end
    cpu_mode = 0;
    repeat (8) step();
    chk("gnt_queue_drained", gq.size(), 0);
    chk("rd_queue_drained", rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
